phv_deparser: RTL and testbench
===============================

// Module: phv_deparser
// PURPOSE
//  Write-side counterpart of the key-field extraction parser. Takes a PHV and a metadata word of
//  KEY_FIELD_NUM key fields, and writes each enabled field back into the PHV at its configured
//  offset. Sits after the match/action stage, before packet emission.
//  Two-stage valid/ready pipeline, per-field offset registers on a 32-bit conf bus, packet counter.
// PARAMETERS
//  PHV_WIDTH         1024  PHV width in bits
//  KEY_FIELD_WIDTH   16    width W of one key field
//  KEY_FIELD_NUM     8     number of key fields in metadata
//  KEY_OFFSET_WIDTH  $clog2(PHV_WIDTH/KEY_FIELD_WIDTH)  offset width, in W-bit units
//  META_WIDTH        128   metadata width, >= KEY_FIELD_NUM*KEY_FIELD_WIDTH
// PORTS
//  i_clk            in   1                 clock
//  i_rst            in   1                 async reset, active-high
//  i_conf_wren      in   1                 conf write strobe
//  i_conf_rden      in   1                 conf read strobe
//  i_conf_addr      in   32                conf address
//  i_conf_wdata     in   32                conf write data
//  o_conf_rdata_valid out 1                read data valid, 1 cycle after i_conf_rden
//  o_conf_rdata     out  32                read data
//  i_phv_in_valid   in   1                 input PHV valid
//  o_phv_in_ready   out  1                 input ready
//  i_phv_in         in   PHV_WIDTH         input PHV
//  i_meta_in        in   META_WIDTH        key fields; field k at [META_WIDTH-1-k*W -: W]
//  o_phv_out_valid  out  1                 output PHV valid
//  i_phv_out_ready  in   1                 downstream ready
//  o_phv_out        out  PHV_WIDTH         modified PHV
// BEHAVIOUR
//  Reset (async, i_rst=1): offsets=0, enables=0, pkt counter=0, both stage valids=0,
//   o_phv_out_valid=0, o_phv_out=0, o_conf_rdata_valid=0, o_conf_rdata=0. In-flight PHVs are
//   dropped and never emitted. After reset o_phv_in_ready=1.
//  Conf map (decode on i_conf_addr[7:0], upper bits ignored):
//   0x00+k (k<KEY_FIELD_NUM): wdata[31]=enable_k, wdata[KEY_OFFSET_WIDTH-1:0]=offset_k.
//     Read returns the same layout, other bits 0.
//   0x20: read = packet counter. Any write clears it to 0.
//   Other addresses: write ignored, read returns 0 with valid.
//   Read is registered: o_conf_rdata_valid=1 exactly one cycle after i_conf_rden.
//   Wren and rden in the same cycle to the same address: the read returns the old value.
//  Field placement: offset o covers PHV bits [PHV_WIDTH-1-o*W -: W] (MSB-first, network order).
//   An offset with o*W+W > PHV_WIDTH (non-power-of-2 PHV) is skipped and the PHV is left unchanged.
//  Pipeline:
//   - Accept = i_phv_in_valid & o_phv_in_ready.
//   - S1 registers PHV, meta and a snapshot of all offset/enable registers. A conf write in the
//     accept cycle is NOT seen by that PHV; it applies from the next accept.
//   - S2 applies fields k=0..N-1 in order, so on overlap the higher k wins. Disabled fields leave
//     the PHV untouched. The result is registered into o_phv_out.
//   - Latency is 2 cycles from accept to o_phv_out_valid when there is no backpressure.
//     Throughput is 1 PHV/cycle.
//  Handshake:
//   - s2_adv = !out_valid | i_phv_out_ready; s1_adv = !s1_valid | s2_adv; o_phv_in_ready = s1_adv.
//   - This is a combinational ready path; depth is 2 entries; no drop, no reorder.
//   - o_phv_out and o_phv_out_valid hold stable while out_valid & !i_phv_out_ready.
//  Counter: 32-bit, +1 per output handshake (o_phv_out_valid & i_phv_out_ready), wraps
//   0xFFFFFFFF->0. A clear and an increment in the same cycle give 0.
// TESTING
//  T1 reset: assert i_rst mid-stream -> all outputs 0 immediately; no stale output after release;
//     ready=1.
//  T2 passthrough: enables=0, PHV=0xA5.. pattern -> identical PHV out 2 cycles later, counter=1.
//  T3 single field: write 0x00 <= 0x80000006, meta field0=0x86DD -> out[927:912]=0x86DD,
//     other bits unchanged.
//  T4 overlap: fields 0 and 1 both at offset 2, meta 0x1111/0x2222 -> out[991:976]=0x2222.
//  T5 backpressure: 4 back-to-back PHVs, i_phv_out_ready=0 for 5 cycles -> ready drops after
//     2 accepts, all 4 emitted in order, held stable while stalled.
//  T6 conf: write in accept cycle (offset 3->5) -> that PHV uses 3, the next uses 5.
//     Read 0x20 -> count; write 0x20 -> 0; read 0x40 -> 0 with valid 1 cycle later.

Source files
------------

// File: rtl/phv_deparser.sv
// Write-side deparser: places enabled key fields from the metadata word back into the PHV
// at per-field configured offsets, through a two-stage valid/ready pipeline.
module phv_deparser #(
  parameter int PHV_WIDTH        = 1024,
  parameter int KEY_FIELD_WIDTH  = 16,
  parameter int KEY_FIELD_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = $clog2(PHV_WIDTH / KEY_FIELD_WIDTH),
  parameter int META_WIDTH       = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_conf_wren,
  input  logic                  i_conf_rden,
  input  logic [31:0]           i_conf_addr,
  input  logic [31:0]           i_conf_wdata,
  output logic                  o_conf_rdata_valid,
  output logic [31:0]           o_conf_rdata,
  input  logic                  i_phv_in_valid,
  output logic                  o_phv_in_ready,
  input  logic [PHV_WIDTH-1:0]  i_phv_in,
  input  logic [META_WIDTH-1:0] i_meta_in,
  output logic                  o_phv_out_valid,
  input  logic                  i_phv_out_ready,
  output logic [PHV_WIDTH-1:0]  o_phv_out
);

  localparam int         SLOT_NUM = PHV_WIDTH / KEY_FIELD_WIDTH;
  localparam int         IDX_W    = (KEY_FIELD_NUM > 1) ? $clog2(KEY_FIELD_NUM) : 1;
  localparam logic [7:0] CNT_ADDR = 8'h20;

  logic [KEY_OFFSET_WIDTH-1:0] offset_r [KEY_FIELD_NUM];
  logic [KEY_FIELD_NUM-1:0]    enable_r;
  logic [31:0]                 pkt_cnt_r;
  logic                        rdata_valid_r;
  logic [31:0]                 rdata_r;
  logic [31:0]                 rdata_s;

  logic                        s1_valid_r;
  logic [PHV_WIDTH-1:0]        s1_phv_r;
  logic [META_WIDTH-1:0]       s1_meta_r;
  logic [KEY_OFFSET_WIDTH-1:0] s1_offset_r [KEY_FIELD_NUM];
  logic [KEY_FIELD_NUM-1:0]    s1_enable_r;
  logic [PHV_WIDTH-1:0]        phv_mod_s;

  logic                        out_valid_r;
  logic [PHV_WIDTH-1:0]        out_phv_r;

  logic [7:0]                  conf_addr_s;
  logic                        field_sel_s;
  logic [IDX_W-1:0]            field_idx_s;
  logic                        s2_adv_s;
  logic                        s1_adv_s;
  logic                        out_fire_s;
  logic                        unused_s;

  assign conf_addr_s = i_conf_addr[7:0];
  assign field_sel_s = (conf_addr_s < 8'(KEY_FIELD_NUM));
  assign field_idx_s = conf_addr_s[IDX_W-1:0];

  assign s2_adv_s   = !out_valid_r | i_phv_out_ready;
  assign s1_adv_s   = !s1_valid_r | s2_adv_s;
  assign out_fire_s = out_valid_r & i_phv_out_ready;

  assign o_phv_in_ready     = s1_adv_s;
  assign o_phv_out_valid    = out_valid_r;
  assign o_phv_out          = out_phv_r;
  assign o_conf_rdata_valid = rdata_valid_r;
  assign o_conf_rdata       = rdata_r;

  assign unused_s = ^{i_conf_addr[31:8], i_conf_wdata[30:KEY_OFFSET_WIDTH]};

  // Per-field offset/enable configuration registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < KEY_FIELD_NUM; k++) offset_r[k] <= '0;
      enable_r <= '0;
    end else if (i_conf_wren && field_sel_s) begin
      enable_r[field_idx_s] <= i_conf_wdata[31];
      offset_r[field_idx_s] <= i_conf_wdata[KEY_OFFSET_WIDTH-1:0];
    end
  end

  // Output handshake counter; a clear outranks a same-cycle increment
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pkt_cnt_r <= 32'd0;
    end else if (i_conf_wren && (conf_addr_s == CNT_ADDR)) begin
      pkt_cnt_r <= 32'd0;
    end else if (out_fire_s) begin
      pkt_cnt_r <= pkt_cnt_r + 32'd1;
    end
  end

  // Read mux over pre-write register values, so read-during-write returns the old value
  always_comb begin
    rdata_s = 32'd0;
    if (field_sel_s) begin
      rdata_s[31]                   = enable_r[field_idx_s];
      rdata_s[KEY_OFFSET_WIDTH-1:0] = offset_r[field_idx_s];
    end else if (conf_addr_s == CNT_ADDR) begin
      rdata_s = pkt_cnt_r;
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Registered read response
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_valid_r <= 1'b0;
      rdata_r       <= 32'd0;
    end else begin
      rdata_valid_r <= i_conf_rden;
      if (i_conf_rden) rdata_r <= rdata_s;
    end
  end

  // Stage 1: capture PHV, metadata and a snapshot of the configuration at accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_r  <= 1'b0;
      s1_phv_r    <= '0;
      s1_meta_r   <= '0;
      s1_enable_r <= '0;
      for (int k = 0; k < KEY_FIELD_NUM; k++) s1_offset_r[k] <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= i_phv_in_valid;
      if (i_phv_in_valid) begin
        s1_phv_r    <= i_phv_in;
        s1_meta_r   <= i_meta_in;
        s1_enable_r <= enable_r;
        for (int k = 0; k < KEY_FIELD_NUM; k++) s1_offset_r[k] <= offset_r[k];
      end
    end
  end

  // Field insertion; iterating only over whole slots drops offsets that would run past the PHV,
  // and the later k overwrites earlier ones on overlap
  always_comb begin
    phv_mod_s = s1_phv_r;
    for (int k = 0; k < KEY_FIELD_NUM; k++) begin
      for (int j = 0; j < SLOT_NUM; j++) begin
        phv_mod_s[PHV_WIDTH-1-j*KEY_FIELD_WIDTH -: KEY_FIELD_WIDTH] =
          (s1_enable_r[k] && (s1_offset_r[k] == KEY_OFFSET_WIDTH'(j)))
            ? s1_meta_r[META_WIDTH-1-k*KEY_FIELD_WIDTH -: KEY_FIELD_WIDTH]
            : phv_mod_s[PHV_WIDTH-1-j*KEY_FIELD_WIDTH -: KEY_FIELD_WIDTH];
      end
    end
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid_r <= 1'b0;
      out_phv_r   <= '0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) out_phv_r <= phv_mod_s;
    end
  end

endmodule

// File: tb/tb_phv_deparser.sv
// Directed bench for phv_deparser: scoreboard of expected PHVs checked at the output handshake,
// plus configuration-bus and reset checks.
module tb_phv_deparser;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_conf_wren = 1'b0;
  logic          i_conf_rden = 1'b0;
  logic [31:0]   i_conf_addr = 32'd0;
  logic [31:0]   i_conf_wdata = 32'd0;
  logic          o_conf_rdata_valid;
  logic [31:0]   o_conf_rdata;
  logic          i_phv_in_valid = 1'b0;
  logic          o_phv_in_ready;
  logic [1023:0] i_phv_in = '0;
  logic [127:0]  i_meta_in = '0;
  logic          o_phv_out_valid;
  logic          i_phv_out_ready = 1'b1;
  logic [1023:0] o_phv_out;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [1023:0] sb[$];
  int            m_off[8];
  logic          m_en[8];
  int            m_cnt = 0;
  logic [1023:0] pa, pb;

  phv_deparser dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_conf_wren(i_conf_wren), .i_conf_rden(i_conf_rden),
    .i_conf_addr(i_conf_addr), .i_conf_wdata(i_conf_wdata),
    .o_conf_rdata_valid(o_conf_rdata_valid), .o_conf_rdata(o_conf_rdata),
    .i_phv_in_valid(i_phv_in_valid), .o_phv_in_ready(o_phv_in_ready),
    .i_phv_in(i_phv_in), .i_meta_in(i_meta_in),
    .o_phv_out_valid(o_phv_out_valid), .i_phv_out_ready(i_phv_out_ready),
    .o_phv_out(o_phv_out)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [1023:0] model_apply(input logic [1023:0] p, input logic [127:0] m);
    logic [1023:0] r = p;
    for (int k = 0; k < 8; k++)
      if (m_en[k] && (m_off[k] * 16 + 16 <= 1024)) r[1023 - m_off[k] * 16 -: 16] = m[127 - k * 16 -: 16];
    return r;
  endfunction

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i * 32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d);
    if (a[7:0] < 8'd8) begin
      m_en[a[2:0]]  = d[31];
      m_off[a[2:0]] = int'(d[5:0]);
    end else if (a[7:0] == 8'h20) begin
      m_cnt = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin
      m_en[k]  = 1'b0;
      m_off[k] = 0;
    end
    m_cnt = 0;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: every valid cycle must show the scoreboard head, popped on handshake
  always @(negedge i_clk) begin
    if (!i_rst && o_phv_out_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $error("FAIL out_unexpected: got valid output expected none pending");
      end else begin
        assert (o_phv_out === sb[0]) else begin
          n_fail++;
          $error("FAIL phv_out: got %h expected %h", o_phv_out, sb[0]);
        end
        if (i_phv_out_ready) begin
          void'(sb.pop_front());
          m_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [1023:0] p, input logic [127:0] m);
    int n = 0;
    i_phv_in_valid = 1'b1;
    i_phv_in       = p;
    i_meta_in      = m;
    @(negedge i_clk);
    while (!o_phv_in_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) begin
      chk32("send_timeout", 32'(o_phv_in_ready), 32'd1);
    end else begin
      sb.push_back(model_apply(p, m));
      @(posedge i_clk);
      #1;
    end
    i_phv_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || o_phv_out_valid) && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk32("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic conf_write(input logic [31:0] a, input logic [31:0] d);
    i_conf_wren  = 1'b1;
    i_conf_addr  = a;
    i_conf_wdata = d;
    @(posedge i_clk);
    #1;
    i_conf_wren = 1'b0;
    model_wr(a, d);
  endtask

  task automatic conf_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    i_conf_rden = 1'b1;
    i_conf_addr = a;
    @(posedge i_clk);
    #1;
    i_conf_rden = 1'b0;
    @(negedge i_clk);
    chk32({tag, "_valid"}, 32'(o_conf_rdata_valid), 32'd1);
    chk32(tag, o_conf_rdata, exp);
    @(negedge i_clk);
    chk32({tag, "_valid_drop"}, 32'(o_conf_rdata_valid), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk32("rst_out_valid", 32'(o_phv_out_valid), 32'd0);
    chk32("rst_out_lsw", o_phv_out[31:0], 32'd0);
    chk32("rst_rdata_valid", 32'(o_conf_rdata_valid), 32'd0);
    chk32("rst_rdata", o_conf_rdata, 32'd0);
    chk32("rst_in_ready", 32'(o_phv_in_ready), 32'd1);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    conf_read(32'h20, 32'd0, "rst_cnt");
    conf_read(32'h00, 32'd0, "rst_field0");

    // Passthrough with exact latency, then counter = 1
    pa = {128{8'hA5}};
    send(pa, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    @(negedge i_clk);
    chk32("lat_cycle1", 32'(o_phv_out_valid), 32'd0);
    @(negedge i_clk);
    chk32("lat_cycle2", 32'(o_phv_out_valid), 32'd1);
    drain();
    conf_read(32'h20, 32'd1, "cnt_after_one");

    // Single field and register readback layout
    conf_write(32'h00, 32'h8000_0006);
    conf_read(32'h00, 32'h8000_0006, "field0_rd");
    conf_write(32'h01, 32'hFFFF_FFC5);
    conf_read(32'h01, 32'h8000_0005, "field1_rd_mask");
    conf_write(32'h01, 32'h0000_0000);
    send(rand_phv(), {16'h86DD, 16'h5555, 96'h1234_5678_9ABC_DEF0_1357_9BDF});
    drain();

    // Overlap: field 1 wins
    conf_write(32'h00, 32'h8000_0002);
    conf_write(32'h01, 32'h8000_0002);
    send(rand_phv(), {16'h1111, 16'h2222, 96'h0});
    drain();

    // Backpressure: two accepts fill the pipe, output held while stalled
    i_phv_out_ready = 1'b0;
    send(rand_phv(), {16'hAAAA, 16'hBBBB, 96'h0});
    send(rand_phv(), {16'hCCCC, 16'hDDDD, 96'h0});
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk32("stall_ready_low", 32'(o_phv_in_ready), 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_phv_out_ready = 1'b1;
    send(rand_phv(), {16'hEEEE, 16'hFFFF, 96'h0});
    send(rand_phv(), {16'h0F0F, 16'hF0F0, 96'h0});
    drain();
    conf_read(32'h20, 32'(m_cnt), "cnt_after_stall");

    // Config write in the accept cycle applies from the next PHV
    conf_write(32'h00, 32'h0000_0000);
    conf_write(32'h01, 32'h0000_0000);
    conf_write(32'h02, 32'h8000_0003);
    pa = rand_phv();
    pb = rand_phv();
    i_conf_wren  = 1'b1;
    i_conf_addr  = 32'h02;
    i_conf_wdata = 32'h8000_0005;
    send(pa, {32'h0, 16'hBEEF, 80'h0});
    i_conf_wren = 1'b0;
    model_wr(32'h02, 32'h8000_0005);
    send(pb, {32'h0, 16'hCAFE, 80'h0});
    drain();

    conf_read(32'h20, 32'(m_cnt), "cnt_read");
    conf_write(32'h20, 32'h1234_5678);
    conf_read(32'h20, 32'd0, "cnt_cleared");
    conf_read(32'h40, 32'd0, "unmapped_rd");
    conf_read(32'hABCD_0102, 32'h8000_0005, "addr_upper_ignored");

    // Same-cycle write and read returns the old value
    i_conf_wren  = 1'b1;
    i_conf_rden  = 1'b1;
    i_conf_addr  = 32'h03;
    i_conf_wdata = 32'h8000_0009;
    @(posedge i_clk);
    #1;
    i_conf_wren = 1'b0;
    i_conf_rden = 1'b0;
    model_wr(32'h03, 32'h8000_0009);
    @(negedge i_clk);
    chk32("rw_same_cycle", o_conf_rdata, 32'd0);
    @(posedge i_clk);
    #1;
    conf_read(32'h03, 32'h8000_0009, "rw_new_value");

    // Reset mid-stream drops in-flight PHVs
    i_phv_out_ready = 1'b0;
    send(rand_phv(), {16'h1234, 16'h5678, 96'h0});
    send(rand_phv(), {16'h9ABC, 16'hDEF0, 96'h0});
    i_rst = 1'b1;
    #1;
    chk32("mid_rst_out_valid", 32'(o_phv_out_valid), 32'd0);
    n_tests++;
    assert (o_phv_out === '0) else begin
      n_fail++;
      $error("FAIL mid_rst_out: got %h expected 0", o_phv_out);
    end
    chk32("mid_rst_rdata", o_conf_rdata, 32'd0);
    chk32("mid_rst_in_ready", 32'(o_phv_in_ready), 32'd1);
    sb.delete();
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_phv_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk32("post_rst_no_stale", 32'(o_phv_out_valid), 32'd0);
    end
    @(posedge i_clk);
    #1;
    chk32("post_rst_ready", 32'(o_phv_in_ready), 32'd1);
    conf_read(32'h03, 32'd0, "post_rst_field3");
    send(rand_phv(), {16'h7777, 112'h0});
    drain();
    conf_read(32'h20, 32'd1, "post_rst_cnt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
